// File: rtl/tt_trig_sequencer.sv
// Trigger sequencer: once armed, waits for a trig_in edge, then emits a delayed burst of pulses.
// Optional TRIG_SYNC_EN adds a 2-flop synchroniser in front of the edge detector.
module tt_trig_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  input  logic             trig_fall,
  input  logic             arm,
  input  logic             abort,
  input  logic             trig_in,
  output logic             pulse_out,
  output logic             armed,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_PULSE,
    S_GAP
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] delay_r;
  logic [CNT_W-1:0] width_r;
  logic [CNT_W-1:0] gap_r;
  logic [CNT_W-1:0] count_r;
  logic             pol;
  logic             trig_src;
  logic             trig_q;
  logic             trig_edge;
  logic             edge_q;
  logic [CNT_W-1:0] width_eff;
  logic [CNT_W-1:0] gap_eff;
  logic [CNT_W-1:0] count_eff;

`ifdef TRIG_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], trig_in};
  end

  assign trig_src = sync_q[1];
`else
  assign trig_src = trig_in;
`endif

  assign trig_edge = pol ? (~trig_src & trig_q) : (trig_src & ~trig_q);
  assign width_eff = (width_r == '0) ? ONE : width_r;
  assign gap_eff   = (gap_r   == '0) ? ONE : gap_r;
  assign count_eff = (count_r == '0) ? ONE : count_r;

  // The edge is registered once so every output can be decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      delay_r   <= '0;
      width_r   <= ONE;
      gap_r     <= ONE;
      count_r   <= ONE;
      pol       <= 1'b0;
      trig_q    <= 1'b0;
      edge_q    <= 1'b0;
      pulse_out <= 1'b0;
      armed     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_idx <= '0;
    end else begin
      trig_q <= trig_src;
      edge_q <= trig_edge & (state == S_ARMED) & ~abort;
      done   <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        pulse_out <= 1'b0;
        armed     <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cfg_we) begin
              case (cfg_addr)
                2'd0: delay_r <= cfg_wdata;
                2'd1: width_r <= cfg_wdata;
                2'd2: gap_r   <= cfg_wdata;
                2'd3: count_r <= cfg_wdata;
              endcase
            end
            if (arm) begin
              state     <= S_ARMED;
              armed     <= 1'b1;
              pol       <= trig_fall;
              pulse_idx <= '0;
            end
          end
          S_ARMED: begin
            if (edge_q) begin
              armed <= 1'b0;
              busy  <= 1'b1;
              if (delay_r != '0) begin
                state <= S_DELAY;
                cnt   <= delay_r - ONE;
              end else begin
                state     <= S_PULSE;
                pulse_out <= 1'b1;
                cnt       <= width_eff - ONE;
                pulse_idx <= pulse_idx + ONE;
              end
            end
          end
          S_DELAY, S_GAP: begin
            if (cnt == '0) begin
              state     <= S_PULSE;
              pulse_out <= 1'b1;
              cnt       <= width_eff - ONE;
              pulse_idx <= pulse_idx + ONE;
            end else begin
              cnt <= cnt - ONE;
            end
          end
          S_PULSE: begin
            if (cnt == '0) begin
              pulse_out <= 1'b0;
              if (pulse_idx == count_eff) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= S_GAP;
                cnt   <= gap_eff - ONE;
              end
            end else begin
              cnt <= cnt - ONE;
            end
          end
          default: begin
            state     <= S_IDLE;
            pulse_out <= 1'b0;
            armed     <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tt_trig_sequencer.sv
// Directed bench for tt_trig_sequencer; expected pulse trains come from a small timing model.
// Build with +define+TRIG_SYNC_EN to exercise the synchroniser variant.
module tb_tt_trig_sequencer;

`ifdef TRIG_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       trig_fall;
  logic       arm;
  logic       abort;
  logic       trig_in;
  logic       pulse_out;
  logic       armed;
  logic       busy;
  logic       done;
  logic [7:0] pulse_idx;

  int n_compared;
  int n_mismatched;

  tt_trig_sequencer #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .trig_fall (trig_fall),
    .arm       (arm),
    .abort     (abort),
    .trig_in   (trig_in),
    .pulse_out (pulse_out),
    .armed     (armed),
    .busy      (busy),
    .done      (done),
    .pulse_idx (pulse_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_compared++;
    if (obs !== expv) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic arm_seq(input logic fall);
    trig_fall = fall;
    arm       = 1'b1;
    step();
    arm       = 1'b0;
    trig_fall = 1'b0;
    checkOutput("armed_after_arm", armed, 1);
  endtask

  // Drives trig_in to lvl (the edge) and checks pulse_out/done every cycle against the model.
  task automatic burst_check(input string tag, input int d, input int w, input int g,
                             input int c, input logic lvl, input logic hold);
    int first;
    int done_off;
    int o;
    logic exp_p;
    first     = d + 1 + SYNC;
    done_off  = first + c * w + (c - 1) * g;
    trig_in   = lvl;
    cfg_we    = hold;
    cfg_addr  = 2'd0;
    cfg_wdata = 8'd9;
    for (int i = 0; i <= done_off + 2; i++) begin
      step();
      o = i - first;
      exp_p = (o >= 0) && (o < c * (w + g)) && ((o % (w + g)) < w);
      checkOutput({tag, "_pulse"}, pulse_out, exp_p);
      checkOutput({tag, "_done"}, done, (i == done_off));
      if (i >= done_off) cfg_we = 1'b0;
    end
    checkOutput({tag, "_idx"}, pulse_idx, c);
    checkOutput({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = 2'd0;
    cfg_wdata = 8'd0;
    trig_fall = 1'b0;
    arm       = 1'b0;
    abort     = 1'b0;
    trig_in   = 1'b0;
    repeat (3) step();
    checkOutput("rst_pulse", pulse_out, 0);
    checkOutput("rst_armed", armed, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_idx", pulse_idx, 0);
    rst = 1'b0;
    repeat (3) step();

    // Default registers: single 1-cycle pulse one clock after the edge
    arm_seq(1'b0);
    burst_check("t1", 0, 1, 1, 1, 1'b1, 1'b0);

    // DELAY=3 WIDTH=2 GAP=4 COUNT=3
    applyStimulus(2'd0, 8'd3);
    applyStimulus(2'd1, 8'd2);
    applyStimulus(2'd2, 8'd4);
    applyStimulus(2'd3, 8'd3);
    trig_in = 1'b0;
    repeat (3) step();
    arm_seq(1'b0);
    burst_check("t2", 3, 2, 4, 3, 1'b1, 1'b0);

    // Falling-edge mode ignores a rising edge, then fires on the falling one
    trig_in = 1'b0;
    repeat (3) step();
    arm_seq(1'b1);
    trig_in = 1'b1;
    for (int i = 0; i < 8 + SYNC; i++) begin
      step();
      checkOutput("t3_rise_pulse", pulse_out, 0);
      checkOutput("t3_rise_busy", busy, 0);
    end
    burst_check("t3", 3, 2, 4, 3, 1'b0, 1'b0);

    // Abort during the second pulse of a 4-pulse burst
    applyStimulus(2'd3, 8'd4);
    repeat (2) step();
    arm_seq(1'b0);
    trig_in = 1'b1;
    step();
    repeat (10 + SYNC) step();
    checkOutput("t4_pre_pulse", pulse_out, 1);
    checkOutput("t4_pre_idx", pulse_idx, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("t4_abort_pulse", pulse_out, 0);
    checkOutput("t4_abort_busy", busy, 0);
    checkOutput("t4_abort_armed", armed, 0);
    checkOutput("t4_abort_done", done, 0);
    checkOutput("t4_abort_idx", pulse_idx, 2);
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("t4_post_done", done, 0);
    end
    trig_in = 1'b0;
    repeat (3) step();
    trig_in = 1'b1;
    for (int i = 0; i < 10 + SYNC; i++) begin
      step();
      checkOutput("t4_edge_pulse", pulse_out, 0);
      checkOutput("t4_edge_busy", busy, 0);
    end

    // WIDTH=0/GAP=0 act as 1; DELAY writes while busy are ignored
    applyStimulus(2'd1, 8'd0);
    applyStimulus(2'd2, 8'd0);
    applyStimulus(2'd3, 8'd3);
    trig_in = 1'b0;
    repeat (3) step();
    arm_seq(1'b0);
    burst_check("t5", 3, 1, 1, 3, 1'b1, 1'b1);
    trig_in = 1'b0;
    repeat (3) step();
    arm_seq(1'b0);
    burst_check("t6", 3, 1, 1, 3, 1'b1, 1'b0);

    // Reset mid-burst returns to reset values
    trig_in = 1'b0;
    repeat (3) step();
    arm_seq(1'b0);
    trig_in = 1'b1;
    repeat (6 + SYNC) step();
    checkOutput("t7_mid_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("t7_rst_pulse", pulse_out, 0);
    checkOutput("t7_rst_busy", busy, 0);
    checkOutput("t7_rst_idx", pulse_idx, 0);
    trig_in = 1'b0;
    repeat (3) step();
    arm_seq(1'b0);
    burst_check("t7", 0, 1, 1, 1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
